freq_bcd_fmt: RTL and testbench

Parametrised sequential binary-to-BCD formatter for the cymometer LCD path. It accepts a binary frequency count over a valid/ready handshake and converts it with a one-bit-per-cycle double-dabble. It then registers packed BCD digits, a leading-zero blanking mask, the most-significant-digit index, an auto-range unit code and an overflow flag. It sits between the frequency counter and the LCD character renderer, generalising the fixed 30-bit/9-digit converter with configurable width, digit count, blanking and range selection.

---
 rtl/freq_fmt_pkg.sv | 23 ++
 rtl/bcd_dabble_digit.sv | 10 +
 rtl/freq_bcd_fmt.sv | 145 ++++++++++++++
 tb/tb_freq_bcd_fmt.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_fmt_pkg.sv
// Shared types for the cymometer BCD formatter:
// FSM states, display unit codes and the digit-index width helper.
package freq_fmt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FMT   = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      UNIT_HZ  = 2'd0,
      UNIT_KHZ = 2'd1,
      UNIT_MHZ = 2'd2,
      UNIT_GHZ = 2'd3
   } unit_e;

   function automatic int msd_w(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_dabble_digit (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/freq_bcd_fmt.sv
// Sequential binary-to-BCD formatter for the LCD path: one double-dabble
// step per cycle, then blanking mask, MSD index, unit range and overflow.
module freq_bcd_fmt
   import freq_fmt_pkg::*;
#(
   parameter int DATA_W   = 30,
   parameter int DIGITS   = 9,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst_n,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [4*DIGITS-1:0]        bcd_out,
   output logic [DIGITS-1:0]          digit_en,
   output logic [msd_w(DIGITS)-1:0]   msd_idx,
   output logic [1:0]                 unit,
   output logic                       ovf
);

   localparam int BW = 4 * DIGITS;
   localparam int IW = msd_w(DIGITS);
   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_e            state_q;
   logic [DATA_W-1:0] data_q;
   logic [BW-1:0]     acc_q;
   logic [CW-1:0]     cnt_q;
   logic              sticky_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic [BW-1:0]     bcd_q;
   logic [DIGITS-1:0] en_q;
   logic [IW-1:0]     msd_q;
   logic [1:0]        unit_q;
   logic              ovf_q;

   logic [BW-1:0]     acc_corr;
   logic [BW-1:0]     acc_shift;
   logic              carry;

   logic [BW-1:0]     bcd_d;
   logic [DIGITS-1:0] en_d;
   logic [IW-1:0]     msd_d;
   logic [1:0]        unit_d;
   int                msd_n;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_dabble_digit u_digit (
         .digit_i (acc_q[4*g +: 4]),
         .digit_o (acc_corr[4*g +: 4])
      );
   end

   // The bit leaving the top digit means the value no longer fits.
   assign carry     = acc_corr[BW-1];
   assign acc_shift = {acc_corr[BW-2:0], data_q[DATA_W-1]};

   always_comb begin
      msd_d = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] != 4'd0) msd_d = IW'(i);
      end
      bcd_d = acc_q;
      if (sticky_q) begin
         msd_d = IW'(DIGITS - 1);
         bcd_d = {DIGITS{4'h9}};
      end
      msd_n = int'(msd_d);
      en_d  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         en_d[i] = BLANK_LZ ? (i <= msd_n) : 1'b1;
      end
      if (msd_n < 3)      unit_d = UNIT_HZ;
      else if (msd_n < 6) unit_d = UNIT_KHZ;
      else if (msd_n < 9) unit_d = UNIT_MHZ;
      else                unit_d = UNIT_GHZ;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         data_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         sticky_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         bcd_q       <= '0;
         en_q        <= '0;
         msd_q       <= '0;
         unit_q      <= UNIT_HZ;
         ovf_q       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  data_q     <= in_data;
                  acc_q      <= '0;
                  sticky_q   <= 1'b0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= SHIFT;
               end
            end
            SHIFT: begin
               data_q   <= data_q << 1;
               acc_q    <= acc_shift;
               sticky_q <= sticky_q | carry;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CW'(DATA_W - 1)) state_q <= FMT;
            end
            FMT: begin
               bcd_q       <= bcd_d;
               en_q        <= en_d;
               msd_q       <= msd_d;
               unit_q      <= unit_d;
               ovf_q       <= sticky_q;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign bcd_out   = bcd_q;
   assign digit_en  = en_q;
   assign msd_idx   = msd_q;
   assign unit      = unit_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_freq_bcd_fmt.sv
// Bench for freq_bcd_fmt: default, 10-digit and no-blanking instances
// share one stimulus stream and are checked against an arithmetic model.
module tb_freq_bcd_fmt;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [29:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;

   logic        a_rdy, a_vld, a_ovf;
   logic [35:0] a_bcd;
   logic [8:0]  a_en;
   logic [3:0]  a_msd;
   logic [1:0]  a_unit;

   logic        b_rdy, b_vld, b_ovf;
   logic [39:0] b_bcd;
   logic [9:0]  b_en;
   logic [3:0]  b_msd;
   logic [1:0]  b_unit;

   logic        c_rdy, c_vld, c_ovf;
   logic [35:0] c_bcd;
   logic [8:0]  c_en;
   logic [3:0]  c_msd;
   logic [1:0]  c_unit;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   freq_bcd_fmt u_dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .in_data(in_data),
      .in_valid(in_valid), .in_ready(a_rdy), .out_valid(a_vld),
      .out_ready(out_ready), .bcd_out(a_bcd), .digit_en(a_en),
      .msd_idx(a_msd), .unit(a_unit), .ovf(a_ovf)
   );

   freq_bcd_fmt #(.DATA_W(30), .DIGITS(10), .BLANK_LZ(1'b1)) u_d10 (
      .sys_clk(clk), .sys_rst_n(rst_n), .in_data(in_data),
      .in_valid(in_valid), .in_ready(b_rdy), .out_valid(b_vld),
      .out_ready(out_ready), .bcd_out(b_bcd), .digit_en(b_en),
      .msd_idx(b_msd), .unit(b_unit), .ovf(b_ovf)
   );

   freq_bcd_fmt #(.DATA_W(30), .DIGITS(9), .BLANK_LZ(1'b0)) u_nb (
      .sys_clk(clk), .sys_rst_n(rst_n), .in_data(in_data),
      .in_valid(in_valid), .in_ready(c_rdy), .out_valid(c_vld),
      .out_ready(out_ready), .bcd_out(c_bcd), .digit_en(c_en),
      .msd_idx(c_msd), .unit(c_unit), .ovf(c_ovf)
   );

   // Decimal formatting computed with plain division.
   function automatic void model(
      input  longint unsigned v,
      input  int              d,
      input  bit              blank,
      output logic [39:0]     bcd,
      output logic [9:0]      en,
      output logic [3:0]      msd,
      output logic [1:0]      un,
      output logic            ov
   );
      longint unsigned lim, t;
      int m;
      lim = 1;
      for (int i = 0; i < d; i++) lim = lim * 10;
      ov  = (v >= lim);
      bcd = '0;
      m   = 0;
      t   = v;
      for (int i = 0; i < d; i++) begin
         if (ov) bcd[4*i +: 4] = 4'h9;
         else    bcd[4*i +: 4] = 4'(t % 10);
         if (!ov && (t % 10) != 0) m = i;
         t = t / 10;
      end
      if (ov) m = d - 1;
      en = '0;
      for (int i = 0; i < d; i++) en[i] = blank ? (i <= m) : 1'b1;
      msd = 4'(m);
      un  = (m / 3 > 3) ? 2'd3 : 2'(m / 3);
   endfunction

   task automatic convert(input logic [29:0] v);
      int guard;
      int lat;
      guard = 0;
      while (!a_rdy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      in_data  = v;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 30'($urandom);
      lat = 0;
      while (!a_vld && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (lat !== 31) begin
         n_fail++;
         $display("FAIL latency v=%0d: got %0d cycles, need 31", v, lat);
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({a_rdy, a_vld, b_rdy, b_vld, c_rdy, c_vld} !== 6'b101010) begin
         n_fail++;
         $display("FAIL reset_hs: got %b need 101010",
                  {a_rdy, a_vld, b_rdy, b_vld, c_rdy, c_vld});
      end
      n_checks++;
      if ({a_bcd, a_en, a_msd, a_unit, a_ovf} !== 52'd0) begin
         n_fail++;
         $display("FAIL reset_out_a: got %h need 0",
                  {a_bcd, a_en, a_msd, a_unit, a_ovf});
      end
      n_checks++;
      if ({b_bcd, b_en, b_msd, b_unit, b_ovf} !== 57'd0) begin
         n_fail++;
         $display("FAIL reset_out_b: got %h need 0",
                  {b_bcd, b_en, b_msd, b_unit, b_ovf});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_known();
      logic [29:0] kv [5];
      logic [35:0] kb [5];
      logic [8:0]  ke [5];
      logic [3:0]  km [5];
      logic [1:0]  ku [5];
      logic        ko [5];
      logic [39:0] eb;
      logic [9:0]  ee;
      logic [3:0]  em;
      logic [1:0]  eu;
      logic        eo;
      kv = '{30'd0, 30'd12345678, 30'd999, 30'd1000, 30'd1073741823};
      kb = '{36'h0, 36'h012345678, 36'h999, 36'h1000, 36'h999999999};
      ke = '{9'h001, 9'h0FF, 9'h007, 9'h00F, 9'h1FF};
      km = '{4'd0, 4'd7, 4'd2, 4'd3, 4'd8};
      ku = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd2};
      ko = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         convert(kv[i]);
         n_checks++;
         if ({a_bcd, a_en, a_msd, a_unit, a_ovf} !==
             {kb[i], ke[i], km[i], ku[i], ko[i]}) begin
            n_fail++;
            $display("FAIL known v=%0d: got %h/%b/%0d/%0d/%b need %h/%b/%0d/%0d/%b",
                     kv[i], a_bcd, a_en, a_msd, a_unit, a_ovf,
                     kb[i], ke[i], km[i], ku[i], ko[i]);
         end
         model(64'(kv[i]), 10, 1'b1, eb, ee, em, eu, eo);
         n_checks++;
         if ({b_vld, b_bcd, b_en, b_msd, b_unit, b_ovf} !==
             {1'b1, eb, ee, em, eu, eo}) begin
            n_fail++;
            $display("FAIL known_d10 v=%0d: got %h need %h", kv[i],
                     {b_vld, b_bcd, b_en, b_msd, b_unit, b_ovf},
                     {1'b1, eb, ee, em, eu, eo});
         end
         handshake();
      end
      n_checks++;
      if ({b_bcd, b_msd, b_unit, b_ovf} !== {40'h1073741823, 4'd9, 2'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL d10_max: got %h/%0d/%0d/%b need 1073741823/9/3/0",
                  b_bcd, b_msd, b_unit, b_ovf);
      end
   endtask

   task automatic test_blank();
      convert(30'd42);
      n_checks++;
      if ({c_en, c_msd, c_bcd} !== {9'h1FF, 4'd1, 36'h42}) begin
         n_fail++;
         $display("FAIL noblank: got en=%b msd=%0d bcd=%h need 111111111/1/42",
                  c_en, c_msd, c_bcd);
      end
      n_checks++;
      if (a_en !== 9'h003) begin
         n_fail++;
         $display("FAIL blank_en: got %b need 000000011", a_en);
      end
      handshake();
   endtask

   task automatic test_backpressure();
      int bad;
      convert(30'd555);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_data  = 30'($urandom);
         @(negedge clk);
         if ({a_vld, a_rdy, a_bcd, a_en, a_msd, a_unit, a_ovf} !==
             {1'b1, 1'b0, 36'h555, 9'h007, 4'd2, 2'd0, 1'b0}) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL hold: got %0d unstable cycles need 0", bad);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if ({a_vld, a_rdy, a_bcd} !== {1'b0, 1'b1, 36'h555}) begin
         n_fail++;
         $display("FAIL release: got vld=%b rdy=%b bcd=%h need 0/1/555",
                  a_vld, a_rdy, a_bcd);
      end
   endtask

   task automatic test_reset_mid();
      in_data  = 30'd999999;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if ({a_rdy, a_vld, a_bcd, a_en, a_msd, a_unit, a_ovf} !== {1'b1, 53'd0}) begin
         n_fail++;
         $display("FAIL mid_reset: got rdy=%b vld=%b out=%h need 1/0/0",
                  a_rdy, a_vld, {a_bcd, a_en, a_msd, a_unit, a_ovf});
      end
      convert(30'd7);
      n_checks++;
      if ({a_bcd, a_en, a_msd, a_ovf} !== {36'h7, 9'h001, 4'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL after_reset: got %h/%b/%0d/%b need 7/000000001/0/0",
                  a_bcd, a_en, a_msd, a_ovf);
      end
      handshake();
   endtask

   task automatic test_random();
      logic [29:0] v;
      int k;
      logic [39:0] eb;
      logic [9:0]  ee;
      logic [3:0]  em;
      logic [1:0]  eu;
      logic        eo;
      for (int n = 0; n < 25; n++) begin
         k = $urandom_range(1, 30);
         v = 30'($urandom) & 30'((64'd1 << k) - 1);
         convert(v);
         model(64'(v), 9, 1'b1, eb, ee, em, eu, eo);
         n_checks++;
         if ({a_bcd, a_en, a_msd, a_unit, a_ovf} !==
             {eb[35:0], ee[8:0], em, eu, eo}) begin
            n_fail++;
            $display("FAIL rand_a v=%0d: got %h need %h", v,
                     {a_bcd, a_en, a_msd, a_unit, a_ovf},
                     {eb[35:0], ee[8:0], em, eu, eo});
         end
         model(64'(v), 10, 1'b1, eb, ee, em, eu, eo);
         n_checks++;
         if ({b_vld, b_bcd, b_en, b_msd, b_unit, b_ovf} !==
             {1'b1, eb, ee, em, eu, eo}) begin
            n_fail++;
            $display("FAIL rand_b v=%0d: got %h need %h", v,
                     {b_vld, b_bcd, b_en, b_msd, b_unit, b_ovf},
                     {1'b1, eb, ee, em, eu, eo});
         end
         model(64'(v), 9, 1'b0, eb, ee, em, eu, eo);
         n_checks++;
         if ({c_vld, c_bcd, c_en, c_msd, c_unit, c_ovf} !==
             {1'b1, eb[35:0], ee[8:0], em, eu, eo}) begin
            n_fail++;
            $display("FAIL rand_c v=%0d: got %h need %h", v,
                     {c_vld, c_bcd, c_en, c_msd, c_unit, c_ovf},
                     {1'b1, eb[35:0], ee[8:0], em, eu, eo});
         end
         handshake();
      end
   endtask

   task automatic test_back_to_back();
      int acc_t [$];
      logic prev;
      int vcnt;
      in_data   = 30'd123;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      prev = a_rdy;
      vcnt = 0;
      for (int t = 0; t < 110; t++) begin
         @(negedge clk);
         if (prev && !a_rdy) acc_t.push_back(t);
         if (a_vld) vcnt++;
         prev = a_rdy;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (acc_t.size() < 3) begin
         n_fail++;
         $display("FAIL b2b_accepts: got %0d need >=3", acc_t.size());
      end else begin
         n_checks++;
         if ((acc_t[1] - acc_t[0]) !== 33 || (acc_t[2] - acc_t[1]) !== 33) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d,%0d need 33,33",
                     acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
         end
      end
      n_checks++;
      if (vcnt < 2 || a_bcd !== 36'h123) begin
         n_fail++;
         $display("FAIL b2b_result: got vcnt=%0d bcd=%h need >=2/123",
                  vcnt, a_bcd);
      end
   endtask

   initial begin
      test_reset();
      test_known();
      test_blank();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
